// File: rtl/sdram_arbiter_if.sv
// Two-port request/ack/done bus plus SDRAM controller handshake for sdram_arbiter.
interface sdram_arbiter_if;
  logic       a_req;
  logic       a_we;
  logic       a_ack;
  logic       a_done;
  logic       b_req;
  logic       b_we;
  logic       b_ack;
  logic       b_done;
  logic [4:0] ctrl_state;
  logic       rd_enable;
  logic       wr_enable;
  logic [9:0] refresh_cnt;
  logic       init_done;
  logic       refresh_pending;
  logic       timeout;

  modport master (
    output a_req, a_we, b_req, b_we, ctrl_state,
    input  a_ack, a_done, b_ack, b_done, rd_enable, wr_enable, refresh_cnt,
           init_done, refresh_pending, timeout
  );

  modport slave (
    input  a_req, a_we, b_req, b_we, ctrl_state,
    output a_ack, a_done, b_ack, b_done, rd_enable, wr_enable, refresh_cnt,
           init_done, refresh_pending, timeout
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin two-port arbiter in front of an SDRAM controller, with refresh
// gating, init tracking and a per-transaction watchdog.
module sdram_arbiter #(
  parameter int unsigned REFRESH_LIMIT = 519,
  parameter int unsigned TIMEOUT       = 255
) (
  input logic            CLK,
  input logic            RESET,
  sdram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StBusy} state_e;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic       port_q, port_d;  // granted port: 0 = A, 1 = B
  logic       we_q, we_d;
  logic       ptr_q, ptr_d;    // round-robin preference: 0 = A, 1 = B
  logic [7:0] wdog_q, wdog_d, wdog_inc;
  logic [9:0] refresh_cnt_q, refresh_cnt_d;
  logic       init_done_q;
  logic       timeout_q, timeout_d;
  logic       rd_en_q, wr_en_q;
  logic       a_ack_q, b_ack_q, a_done_q, b_done_q;
  logic       ack_d, done_d;
  logic       refresh_pending;
  logic       ctrl_access;

  assign refresh_pending = 32'(refresh_cnt_q) >= REFRESH_LIMIT;
  assign ctrl_access     = bus.ctrl_state[4];

  always_comb begin
    refresh_cnt_d = refresh_cnt_q;
    if (bus.ctrl_state == 5'b00001) begin
      refresh_cnt_d = '0;
    end else if (refresh_cnt_q != 10'h3ff) begin
      refresh_cnt_d = refresh_cnt_q + 10'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    we_d      = we_q;
    ptr_d     = ptr_q;
    wdog_d    = '0;
    wdog_inc  = wdog_q + 8'd1;
    timeout_d = timeout_q;
    ack_d     = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (init_done_q && !refresh_pending && (bus.a_req || bus.b_req)) begin
          // A lone requester wins; on contention the pointer decides.
          port_d  = (bus.a_req && bus.b_req) ? ptr_q : bus.b_req;
          we_d    = port_d ? bus.b_we : bus.a_we;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wdog_d = wdog_inc;
        if (ctrl_access) begin
          state_d = StBusy;
          ack_d   = 1'b1;
        end
      end
      StBusy: begin
        wdog_d = wdog_inc;
        if (bus.ctrl_state == 5'b00000) begin
          state_d = StIdle;
          done_d  = 1'b1;
          ptr_d   = ~port_q;
        end
      end
      default: state_d = StIdle;
    endcase

    // Watchdog abort wins over any handshake completing in the same cycle.
    if (state_q != StIdle && wdog_inc == TimeoutVal) begin
      state_d   = StIdle;
      ack_d     = 1'b0;
      done_d    = 1'b0;
      ptr_d     = ptr_q;
      wdog_d    = '0;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= StIdle;
      port_q        <= 1'b0;
      we_q          <= 1'b0;
      ptr_q         <= 1'b0;
      wdog_q        <= '0;
      refresh_cnt_q <= '0;
      init_done_q   <= 1'b0;
      timeout_q     <= 1'b0;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      a_done_q      <= 1'b0;
      b_done_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      port_q        <= port_d;
      we_q          <= we_d;
      ptr_q         <= ptr_d;
      wdog_q        <= wdog_d;
      refresh_cnt_q <= refresh_cnt_d;
      timeout_q     <= timeout_d;
      if (bus.ctrl_state == 5'b00000) begin
        init_done_q <= 1'b1;
      end
      rd_en_q  <= (state_d == StIssue) && !we_d;
      wr_en_q  <= (state_d == StIssue) && we_d;
      a_ack_q  <= ack_d && !port_q;
      b_ack_q  <= ack_d && port_q;
      a_done_q <= done_d && !port_q;
      b_done_q <= done_d && port_q;
    end
  end

  assign bus.rd_enable       = rd_en_q;
  assign bus.wr_enable       = wr_en_q;
  assign bus.a_ack           = a_ack_q;
  assign bus.b_ack           = b_ack_q;
  assign bus.a_done          = a_done_q;
  assign bus.b_done          = b_done_q;
  assign bus.refresh_cnt     = refresh_cnt_q;
  assign bus.init_done       = init_done_q;
  assign bus.refresh_pending = refresh_pending;
  assign bus.timeout         = timeout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: vector table plus scoreboarded
// controller model and hand-written refresh/timeout/reset sequences.
module tb_sdram_arbiter;

  typedef struct packed {
    logic port;  // 0 = A, 1 = B
    logic we;
  } exp_t;

  typedef struct packed {
    logic a_req;
    logic a_we;
    logic b_req;
    logic b_we;
    logic port;
    logic we;
  } vec_t;

  logic CLK;
  logic RESET;
  bit   mon_en;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];
  vec_t tbl[7];

  sdram_arbiter_if bus ();

  sdram_arbiter #(
    .REFRESH_LIMIT(519),
    .TIMEOUT      (255)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mutual exclusion of acks, dones and enables, every cycle.
  always @(negedge CLK) begin
    if (mon_en && RESET) begin
      chk("exclusive", {29'd0, bus.a_ack & bus.b_ack, bus.a_done & bus.b_done,
                        bus.rd_enable & bus.wr_enable}, 0);
    end
  end

  // Controller model: accept the pending command, then finish it.
  task automatic serve(input bit drop);
    exp_t e;
    int   n = 0;
    while (!(bus.rd_enable || bus.wr_enable) && n < 40) begin
      tick();
      n++;
    end
    chk("grant_wait", 32'(n < 40 && sb.size() > 0), 1);
    if (n >= 40 || sb.size() == 0) return;
    e = sb.pop_front();
    chk("we", {30'd0, bus.wr_enable, bus.rd_enable}, e.we ? 2 : 1);
    bus.ctrl_state = bus.wr_enable ? 5'b11000 : 5'b10000;
    tick();
    if (drop) begin
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
    end
    chk("ack", {30'd0, bus.a_ack, bus.b_ack}, e.port ? 1 : 2);
    chk("en_off", {30'd0, bus.rd_enable, bus.wr_enable}, 0);
    bus.ctrl_state = e.we ? 5'b11100 : 5'b10100;
    tick();
    chk("no_early_done", {30'd0, bus.a_done, bus.b_done}, 0);
    bus.ctrl_state = 5'b00000;
    tick();
    chk("done", {30'd0, bus.a_done, bus.b_done}, e.port ? 1 : 2);
  endtask

  task automatic do_refresh();
    bus.ctrl_state = 5'b00001;
    tick();
    chk("refresh_clear", 32'(bus.refresh_cnt), 0);
    for (int s = 2; s <= 4; s++) begin
      bus.ctrl_state = 5'(s);
      tick();
    end
    bus.ctrl_state = 5'b00000;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int   n;
    logic bad;
    n_cmp  = 0;
    n_err  = 0;
    mon_en = 1'b0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.b_req = 1'b0; bus.b_we = 1'b0;
    bus.ctrl_state = 5'b01000;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset values
    RESET = 1'b1;
    #2 RESET = 1'b0;
    #1;
    chk("reset_outputs", {13'd0, bus.rd_enable, bus.wr_enable, bus.a_ack, bus.b_ack,
                          bus.a_done, bus.b_done, bus.refresh_cnt, bus.init_done,
                          bus.timeout}, 0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    mon_en = 1'b1;

    // Init: controller busy initialising, A write waits for init_done
    bus.a_req = 1'b1;
    bus.a_we  = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rd_enable || bus.wr_enable || bus.a_ack || bus.init_done) bad = 1'b1;
    end
    chk("init_hold", 32'(bad), 0);
    bus.ctrl_state = 5'b00000;
    tick();
    chk("init_done", 32'(bus.init_done), 1);
    chk("init_no_grant_yet", {30'd0, bus.rd_enable, bus.wr_enable}, 0);
    tick();
    chk("init_wr_enable", {30'd0, bus.rd_enable, bus.wr_enable}, 1);
    sb.push_back('{1'b0, 1'b1});
    serve(1'b1);

    // Vector table: pointer now favours B
    for (int i = 0; i < 7; i++) begin
      bus.a_req = tbl[i].a_req;
      bus.a_we  = tbl[i].a_we;
      bus.b_req = tbl[i].b_req;
      bus.b_we  = tbl[i].b_we;
      sb.push_back('{tbl[i].port, tbl[i].we});
      serve(1'b1);
    end

    // Continuous contention alternates A,B,A,B
    do_refresh();
    bus.a_req = 1'b1; bus.a_we = 1'b0;
    bus.b_req = 1'b1; bus.b_we = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back('{1'(i % 2), 1'b0});
    for (int i = 0; i < 4; i++) serve(1'b0);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;

    // Refresh threshold withholds grants until the controller refreshes
    n = 0;
    while (!bus.refresh_pending && n < 1100) begin
      tick();
      n++;
    end
    chk("refresh_pending_at_limit", 32'(bus.refresh_cnt), 519);
    bus.b_req = 1'b1;
    bus.b_we  = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.rd_enable || bus.wr_enable || bus.b_ack) bad = 1'b1;
    end
    chk("refresh_blocks_grant", 32'(bad), 0);
    sb.push_back('{1'b1, 1'b0});
    do_refresh();
    chk("refresh_pending_clear", 32'(bus.refresh_pending), 0);
    serve(1'b1);

    // Controller refresh during ISSUE keeps the write enable up
    bus.a_req = 1'b1;
    bus.a_we  = 1'b1;
    tick();
    chk("issue_wr", 32'(bus.wr_enable), 1);
    bad = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      bus.ctrl_state = 5'(s);
      tick();
      if (!bus.wr_enable || bus.a_ack || bus.b_ack) bad = 1'b1;
    end
    chk("refresh_holds_issue", 32'(bad), 0);
    bus.ctrl_state = 5'b00000;
    sb.push_back('{1'b0, 1'b1});
    serve(1'b1);

    // Watchdog: controller never accepts
    do_refresh();
    bus.b_req = 1'b1;
    bus.b_we  = 1'b0;
    tick();
    chk("wd_issue", 32'(bus.rd_enable), 1);
    n = 0;
    bad = 1'b0;
    while ((bus.rd_enable || bus.wr_enable) && n < 300) begin
      tick();
      n++;
      if (bus.a_ack || bus.b_ack) bad = 1'b1;
    end
    bus.b_req = 1'b0;
    chk("wd_cycles", 32'(n), 255);
    chk("wd_timeout", 32'(bus.timeout), 1);
    chk("wd_no_ack", 32'(bad), 0);
    tick();
    tick();
    chk("wd_idle", {28'd0, bus.rd_enable, bus.wr_enable, bus.a_done, bus.b_done}, 0);
    // Pointer still favours B after the abort
    bus.a_req = 1'b1; bus.a_we = 1'b0;
    bus.b_req = 1'b1; bus.b_we = 1'b0;
    sb.push_back('{1'b1, 1'b0});
    serve(1'b1);
    chk("wd_sticky", 32'(bus.timeout), 1);

    // Reset during BUSY with the pointer on B
    bus.a_req = 1'b1;
    bus.a_we  = 1'b0;
    sb.push_back('{1'b0, 1'b0});
    serve(1'b1);
    bus.b_req = 1'b1;
    bus.b_we  = 1'b1;
    tick();
    bus.ctrl_state = 5'b11000;
    tick();
    bus.b_req = 1'b0;
    chk("rst_pre_ack", 32'(bus.b_ack), 1);
    bus.ctrl_state = 5'b11100;
    #2 RESET = 1'b0;
    #1;
    chk("rst_async_outputs", {13'd0, bus.rd_enable, bus.wr_enable, bus.a_ack, bus.b_ack,
                              bus.a_done, bus.b_done, bus.refresh_cnt, bus.init_done,
                              bus.timeout}, 0);
    bus.ctrl_state = 5'b00000;
    tick();
    tick();
    RESET = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.a_done || bus.b_done) bad = 1'b1;
    end
    chk("rst_no_done", 32'(bad), 0);
    bus.a_req = 1'b1; bus.a_we = 1'b0;
    bus.b_req = 1'b1; bus.b_we = 1'b0;
    sb.push_back('{1'b0, 1'b0});
    serve(1'b1);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
